dot_product_accumulator: RTL and testbench
==========================================

# dot_product_accumulator

Sequencing stage that turns a stream of IEEE-754 single-precision products into one dot-product result for the matrix multiplier. It accepts products from the upstream multiplier over a stb/ack handshake, drives the floating-point `adder` with the running sum and each new product, and captures the adder's `output_z` as the new running sum. After `N` terms it presents the finished element downstream, then clears the sum for the next element.

## Interface
- `N`, 4: products per dot product; legal range 1..255.
- `WIDTH`, 32: word width; fixed at 32, matching `adder`.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `prod`  in  32  product from the multiplier.
- `prod_stb`  in  1  `prod` valid.
- `prod_ack`  out  1  product accepted.
- `add_a`, `add_a_stb`  out  32, 1  running sum to `adder.input_a`.
- `add_a_ack`  in  1  from `adder.input_a_ack`.
- `add_b`, `add_b_stb`  out  32, 1  product to `adder.input_b`.
- `add_b_ack`  in  1  from `adder.input_b_ack`.
- `add_z`, `add_z_stb`  in  32, 1  from `adder.output_z` and `output_z_stb`.
- `add_z_ack`  out  1  to `adder.output_z_ack`.
- `sum`, `sum_stb`  out  32, 1  finished dot product.
- `sum_ack`  in  1  downstream accepted `sum`.
- `busy`  out  1  high in any state other than GET_PROD with `cnt == 0`.

## Operation
- Internal registers: `acc` (32 bits), `cnt` (8 bits), `prod_r` (32 bits), and the per-operand flags `a_done` and `b_done`.
- Handshake rule: a transfer occurs at a rising edge where stb and ack are both 1. The sender holds its data stable from stb rising until that edge. A strobe or ack driven by this block falls on the cycle after the transfer.
- State GET_PROD: `prod_ack` is 1. On a transfer, `prod_r <= prod` and the state goes to SEND_ADD.
- State SEND_ADD: drives `add_a = acc` and `add_b = prod_r`.
  - `add_a_stb` stays 1 until its own transfer, which sets `a_done`. `add_b_stb` behaves the same way and sets `b_done`.
  - The two operands may be accepted in either order or on the same edge.
  - When both flags are set, both flags clear and the state goes to WAIT_Z.
- State WAIT_Z: `add_z_ack` is 1. On a transfer, `acc <= add_z` and `cnt <= cnt + 1`.
  - If the new `cnt` equals `N`, the state goes to PUT_SUM.
  - Otherwise it goes to GET_PROD.
- State PUT_SUM: `sum = acc` and `sum_stb` is 1. On a transfer, `acc <= 32'h00000000`, `cnt <= 0`, and the state goes to GET_PROD.
- `acc` starts at +0.0, so the first add is 0 + p0. -0.0 inputs rely on the adder's sign rule and are not special-cased.
- No arithmetic is performed here: NaN and Inf products pass through the adder unchanged by this block.
- `prod_stb` arriving in any state other than GET_PROD is ignored and not acked, so the upstream stage stalls.
- N = 1: one add per element, then PUT_SUM.

## Timing
- Reset values: state is GET_PROD; `acc`, `prod_r`, `cnt`, `add_a`, `add_b`, and `sum` are 0; every stb and ack output is 0.
  - `prod_ack` rises on the first clock edge after `rst` deasserts.
- Reset asserted mid-operation aborts immediately: the partial sum is discarded and the in-flight product is dropped. `adder` shares `rst` and resets together with this block.
- Per-term latency = 1 (GET_PROD) + adder input-accept cycles + adder compute latency + 1 (WAIT_Z transfer). The bench must not assume a fixed adder latency.
- After the last term, `sum_stb` rises on the cycle after the final `add_z` transfer.
- If `sum_ack` is held at 1, `prod_ack` rises on the cycle after the `sum` transfer.
- `sum_ack` held at 0 stalls indefinitely with `sum` stable. No new product is accepted during the stall.

## Configuration
- `ACC_FIRST_BYPASS_EN` defined: the first product of each element (`cnt == 0`) is written straight to `acc`, skipping SEND_ADD and WAIT_Z.
  - That product costs one cycle, and each element uses N−1 adder operations.
  - With N = 1 the product goes directly to PUT_SUM.
- `ACC_FIRST_BYPASS_EN` undefined: every product goes through the adder as described in Operation (N adds, starting from +0.0).

## Test plan
- N=4; products 0x3F800000, 0x40000000, 0x40400000, 0x40800000 (1.0, 2.0, 3.0, 4.0) -> `sum` = 0x41200000 (10.0) with a single `sum_stb` pulse held until `sum_ack`.
- Products 0x3F800000 and 0xBF800000 in an N=2 build -> `sum` = 0x00000000; a second element 2.0 + 2.0 then gives 0x40800000, which proves `acc` and `cnt` cleared.
- `sum_ack` held 0 for 20 cycles -> `sum_stb` stays 1, `sum` stays stable, and `prod_ack` stays 0 throughout.
- `add_b_ack` delayed 5 cycles after `add_a_ack` -> `add_a_stb` drops after its own transfer, `add_b_stb` holds until its own, and exactly one add is issued.
- `rst` pulsed low after 2 of 4 terms -> all outputs return to their reset values. The next 4 products 1.0 each then give 0x40800000.
- With `ACC_FIRST_BYPASS_EN`, N=4, products 1.0 through 4.0 -> `sum` = 0x41200000 and exactly 3 `add_z` transfers are counted.

Source files
------------

// File: rtl/dot_product_accumulator.sv
// Dot-product sequencer: streams N float products through an external adder and
// presents the finished sum. Optional feature macro: ACC_FIRST_BYPASS_EN (first term loads acc directly).
module dot_product_accumulator #(
    parameter int N     = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] prod,
    input  logic             prod_stb,
    output logic             prod_ack,
    output logic [WIDTH-1:0] add_a,
    output logic             add_a_stb,
    input  logic             add_a_ack,
    output logic [WIDTH-1:0] add_b,
    output logic             add_b_stb,
    input  logic             add_b_ack,
    input  logic [WIDTH-1:0] add_z,
    input  logic             add_z_stb,
    output logic             add_z_ack,
    output logic [WIDTH-1:0] sum,
    output logic             sum_stb,
    input  logic             sum_ack,
    output logic             busy
);
    typedef enum logic [1:0] {GET_PROD, SEND_ADD, WAIT_Z, PUT_SUM} state_t;

    localparam logic [7:0] N_L = 8'(N);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] prod_r_q, prod_r_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             a_done_q, a_done_d;
    logic             b_done_q, b_done_d;
    logic             prod_ack_q, prod_ack_d;
    logic             add_a_stb_q, add_a_stb_d;
    logic             add_b_stb_q, add_b_stb_d;
    logic             add_z_ack_q, add_z_ack_d;
    logic             sum_stb_q, sum_stb_d;
    logic             busy_q, busy_d;
    logic [7:0]       cnt_inc_s;
    logic             a_xfer_s, b_xfer_s;

    // Next-state, datapath and next-output computation
    always_comb begin
        cnt_inc_s = cnt_q + 8'd1;
        a_xfer_s  = add_a_stb_q & add_a_ack;
        b_xfer_s  = add_b_stb_q & add_b_ack;
        state_d   = state_q;
        acc_d     = acc_q;
        prod_r_d  = prod_r_q;
        cnt_d     = cnt_q;
        a_done_d  = a_done_q;
        b_done_d  = b_done_q;
        case (state_q)
            GET_PROD: begin
                if (prod_stb && prod_ack_q) begin
`ifdef ACC_FIRST_BYPASS_EN
                    if (cnt_q == 8'd0) begin
                        // First term of an element needs no add; ack stays up for the next term
                        acc_d = prod;
                        cnt_d = 8'd1;
                        if (N_L == 8'd1) begin
                            state_d = PUT_SUM;
                        end else begin
                            state_d = GET_PROD;
                        end
                    end else begin
                        prod_r_d = prod;
                        state_d  = SEND_ADD;
                    end
`else
                    prod_r_d = prod;
                    state_d  = SEND_ADD;
`endif
                end else begin
                    state_d = GET_PROD;
                end
            end
            SEND_ADD: begin
                a_done_d = a_done_q | a_xfer_s;
                b_done_d = b_done_q | b_xfer_s;
                if (a_done_d && b_done_d) begin
                    a_done_d = 1'b0;
                    b_done_d = 1'b0;
                    state_d  = WAIT_Z;
                end else begin
                    state_d = SEND_ADD;
                end
            end
            WAIT_Z: begin
                if (add_z_stb && add_z_ack_q) begin
                    acc_d = add_z;
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == N_L) begin
                        state_d = PUT_SUM;
                    end else begin
                        state_d = GET_PROD;
                    end
                end else begin
                    state_d = WAIT_Z;
                end
            end
            PUT_SUM: begin
                if (sum_stb_q && sum_ack) begin
                    acc_d   = {WIDTH{1'b0}};
                    cnt_d   = 8'd0;
                    state_d = GET_PROD;
                end else begin
                    state_d = PUT_SUM;
                end
            end
            default: begin
                state_d = GET_PROD;
            end
        endcase
        // Handshake outputs are registered views of the next state
        prod_ack_d  = (state_d == GET_PROD);
        add_a_stb_d = (state_d == SEND_ADD) && !a_done_d;
        add_b_stb_d = (state_d == SEND_ADD) && !b_done_d;
        add_z_ack_d = (state_d == WAIT_Z);
        sum_stb_d   = (state_d == PUT_SUM);
        busy_d      = !((state_d == GET_PROD) && (cnt_d == 8'd0));
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= GET_PROD;
            acc_q       <= {WIDTH{1'b0}};
            prod_r_q    <= {WIDTH{1'b0}};
            cnt_q       <= 8'd0;
            a_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            prod_ack_q  <= 1'b0;
            add_a_stb_q <= 1'b0;
            add_b_stb_q <= 1'b0;
            add_z_ack_q <= 1'b0;
            sum_stb_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            prod_r_q    <= prod_r_d;
            cnt_q       <= cnt_d;
            a_done_q    <= a_done_d;
            b_done_q    <= b_done_d;
            prod_ack_q  <= prod_ack_d;
            add_a_stb_q <= add_a_stb_d;
            add_b_stb_q <= add_b_stb_d;
            add_z_ack_q <= add_z_ack_d;
            sum_stb_q   <= sum_stb_d;
            busy_q      <= busy_d;
        end
    end

    assign prod_ack  = prod_ack_q;
    assign add_a     = acc_q;
    assign add_a_stb = add_a_stb_q;
    assign add_b     = prod_r_q;
    assign add_b_stb = add_b_stb_q;
    assign add_z_ack = add_z_ack_q;
    assign sum       = acc_q;
    assign sum_stb   = sum_stb_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Randomized bench for dot_product_accumulator with a behavioural adder and an
// integer-arithmetic reference for the expected dot products.
module tb_dot_product_accumulator;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] prod;
    logic        prod_stb;
    logic        prod_ack;
    logic [31:0] add_a, add_b, add_z, sum;
    logic        add_a_stb, add_a_ack, add_b_stb, add_b_ack;
    logic        add_z_stb, add_z_ack, sum_stb, sum_ack, busy;

    always #5 clk = ~clk;

    dot_product_accumulator #(.N(N), .WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .prod(prod), .prod_stb(prod_stb), .prod_ack(prod_ack),
        .add_a(add_a), .add_a_stb(add_a_stb), .add_a_ack(add_a_ack),
        .add_b(add_b), .add_b_stb(add_b_stb), .add_b_ack(add_b_ack),
        .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
        .sum(sum), .sum_stb(sum_stb), .sum_ack(sum_ack),
        .busy(busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          elem_sum = 0;
    int          elem_n = 0;
    int          exp_adds = 0;
    int          z_xfers = 0;
    int          sums_seen = 0;
    logic [31:0] last_sum = 32'h0;
    int          force_a = -1;
    int          force_b = -1;
    int          sack_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Exact float encoding of a small integer
    function automatic logic [31:0] int_to_fp(input int v);
        logic [31:0] m;
        logic [7:0]  ex;
        int          e;
        if (v == 0) return 32'h0;
        m = (v < 0) ? 32'(-v) : 32'(v);
        e = 0;
        for (int i = 0; i < 32; i++) if (m[i]) e = i;
        m  = m << (23 - e);
        ex = 8'(e + 127);
        return {v < 0, ex, m[22:0]};
    endfunction

    function automatic int fp_to_int(input logic [31:0] f);
        logic [31:0] m;
        int          e;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        m = {8'h00, 1'b1, f[22:0]} >> (23 - e);
        return f[31] ? -int'(m) : int'(m);
    endfunction

    task automatic push_prod(input int v);
        int t = 0;
        @(negedge clk);
        prod     = int_to_fp(v);
        prod_stb = 1'b1;
        while (prod_ack !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            flag_fail("prod_accept", "prod_ack never rose");
            prod_stb = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            prod_stb = 1'b0;
`ifdef ACC_FIRST_BYPASS_EN
            if (elem_n != 0) exp_adds++;
`else
            exp_adds++;
`endif
            elem_sum += v;
            elem_n++;
            if (elem_n == N) begin
                exp_q.push_back(int_to_fp(elem_sum));
                elem_sum = 0;
                elem_n   = 0;
            end
        end
    endtask

    task automatic wait_sum_stb(input logic lvl, input string name);
        int t = 0;
        while (sum_stb !== lvl && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) flag_fail(name, "sum_stb wait expired");
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) flag_fail(name, "expected sums never delivered");
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_strobes"}, 32'({prod_ack, add_a_stb, add_b_stb, add_z_ack, sum_stb, busy}), 32'h0);
        check({name, "_add_a"}, add_a, 32'h0);
        check({name, "_add_b"}, add_b, 32'h0);
        check({name, "_sum"}, sum, 32'h0);
    endtask

    // Behavioural adder: random accept delays and compute latency
    initial begin : adder_model
        logic        have_a, have_b, computing, pa_stb, pb_stb, pz_ack;
        logic [31:0] a_v, b_v, pa_v, pb_v, z_v;
        int          a_wait, b_wait, z_wait;
        have_a = 0; have_b = 0; computing = 0; pa_stb = 0; pb_stb = 0; pz_ack = 0;
        a_v = 0; b_v = 0; pa_v = 0; pb_v = 0; z_v = 0; a_wait = 0; b_wait = 0; z_wait = 0;
        add_a_ack = 0; add_b_ack = 0; add_z_stb = 0; add_z = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                have_a = 0; have_b = 0; computing = 0; pa_stb = 0; pb_stb = 0; pz_ack = 0;
                add_a_ack = 0; add_b_ack = 0; add_z_stb = 0; z_xfers = 0;
            end else begin
                if (pa_stb && add_a_ack) begin
                    if (have_a) flag_fail("add_a_dup", "second operand A before result");
                    have_a = 1; a_v = pa_v;
                end
                if (pb_stb && add_b_ack) begin
                    if (have_b) flag_fail("add_b_dup", "second operand B before result");
                    have_b = 1; b_v = pb_v;
                end
                if (add_z_stb && pz_ack) begin
                    add_z_stb = 0;
                    z_xfers++;
                end
                if (have_a && have_b) begin
                    z_v = int_to_fp(fp_to_int(a_v) + fp_to_int(b_v));
                    z_wait = int'($urandom_range(0, 4));
                    computing = 1; have_a = 0; have_b = 0;
                end
                if (computing) begin
                    if (z_wait == 0) begin
                        add_z = z_v; add_z_stb = 1; computing = 0;
                    end else begin
                        z_wait--;
                    end
                end
                if (add_a_stb && !have_a && !computing && !add_z_stb) begin
                    if (a_wait == 0) add_a_ack = 1;
                    else begin add_a_ack = 0; a_wait--; end
                end else begin
                    add_a_ack = 0;
                    a_wait = (force_a >= 0) ? force_a : int'($urandom_range(0, 3));
                end
                if (add_b_stb && !have_b && !computing && !add_z_stb) begin
                    if (b_wait == 0) add_b_ack = 1;
                    else begin add_b_ack = 0; b_wait--; end
                end else begin
                    add_b_ack = 0;
                    b_wait = (force_b >= 0) ? force_b : int'($urandom_range(0, 3));
                end
                pa_stb = add_a_stb; pa_v = add_a;
                pb_stb = add_b_stb; pb_v = add_b;
                pz_ack = add_z_ack;
            end
        end
    end

    initial begin : sum_ack_driver
        sum_ack = 0;
        forever begin
            @(posedge clk);
            #1;
            case (sack_mode)
                0:       sum_ack = 0;
                1:       sum_ack = 1;
                default: sum_ack = ($urandom_range(0, 3) == 0);
            endcase
        end
    end

    // Per-cycle compare of DUT outputs against the reference
    initial begin : compare
        logic        c_a_x, c_b_x, c_s_x, c_s_stb, a_first, b_first;
        logic [31:0] c_sum_v, junk;
        c_a_x = 0; c_b_x = 0; c_s_x = 0; c_s_stb = 0; a_first = 0; b_first = 0; c_sum_v = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                c_a_x = 0; c_b_x = 0; c_s_x = 0; c_s_stb = 0; a_first = 0; b_first = 0;
            end else begin
                if (c_a_x) check("add_a_stb_drop", 32'(add_a_stb), 32'h0);
                if (c_b_x) check("add_b_stb_drop", 32'(add_b_stb), 32'h0);
                if (c_a_x && c_b_x) begin a_first = 0; b_first = 0; end
                else if (c_a_x) begin if (b_first) b_first = 0; else a_first = 1; end
                else if (c_b_x) begin if (a_first) a_first = 0; else b_first = 1; end
                if (a_first) check("add_b_stb_hold", 32'(add_b_stb), 32'h1);
                if (b_first) check("add_a_stb_hold", 32'(add_a_stb), 32'h1);
                if (c_s_x) begin
                    if (exp_q.size() > 0) junk = exp_q.pop_front();
                    last_sum = c_sum_v;
                    sums_seen++;
                    check("sum_stb_drop", 32'(sum_stb), 32'h0);
                end else if (c_s_stb && sum_stb) begin
                    check("sum_stable", sum, c_sum_v);
                end
                if (sum_stb) begin
                    if (exp_q.size() == 0) flag_fail("sum_value", "sum_stb with no expected sum");
                    else check("sum_value", sum, exp_q[0]);
                    check("prod_ack_in_put_sum", 32'(prod_ack), 32'h0);
                    check("busy_in_put_sum", 32'(busy), 32'h1);
                end
                if (prod_ack) check("busy_vs_count", 32'(busy), 32'(elem_n != 0));
                c_a_x = add_a_stb & add_a_ack;
                c_b_x = add_b_stb & add_b_ack;
                c_s_x = sum_stb & sum_ack;
                c_s_stb = sum_stb;
                c_sum_v = sum;
            end
        end
    end

    initial begin : main
        prod = 32'h0; prod_stb = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        check("model_10", int_to_fp(10), 32'h41200000);
        check("model_m1", int_to_fp(-1), 32'hBF800000);
        check("model_back", 32'(fp_to_int(32'h40400000)), 32'd3);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        #1 check("prod_ack_before_edge", 32'(prod_ack), 32'h0);
        @(negedge clk);
        check("prod_ack_after_reset", 32'(prod_ack), 32'h1);

        // 1+2+3+4 with a 20-cycle downstream stall
        sack_mode = 0;
        push_prod(1); push_prod(2); push_prod(3); push_prod(4);
        wait_sum_stb(1'b1, "tp1_sum_rise");
        check("tp1_sum", sum, 32'h41200000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_sum_stb", 32'(sum_stb), 32'h1);
            check("stall_prod_ack", 32'(prod_ack), 32'h0);
            check("stall_sum", sum, 32'h41200000);
        end
        sack_mode = 1;
        wait_sum_stb(1'b0, "tp1_sum_fall");
        check("prod_ack_after_sum", 32'(prod_ack), 32'h1);
        check("tp1_one_sum", 32'(sums_seen), 32'd1);

        // Cancellation then a fresh element; operand B accepted 5 cycles late
        force_a = 0; force_b = 5;
        push_prod(1); push_prod(-1); push_prod(3); push_prod(-3);
        wait_drain("cancel_drain");
        check("cancel_sum", last_sum, 32'h00000000);
        push_prod(2); push_prod(2); push_prod(0); push_prod(0);
        wait_drain("clear_drain");
        check("clear_sum", last_sum, 32'h40800000);
        check("delayed_b_adds", 32'(z_xfers), 32'(exp_adds));
        force_a = -1; force_b = -1;

        // Reset after 2 of 4 terms
        push_prod(5); push_prod(6);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        exp_q.delete(); elem_n = 0; elem_sum = 0; exp_adds = 0;
        #1 check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        push_prod(1); push_prod(1); push_prod(1); push_prod(1);
        wait_drain("post_reset_drain");
        check("post_reset_sum", last_sum, 32'h40800000);

        // Randomized elements with random downstream backpressure
        sack_mode = 2;
        for (int e = 0; e < 25; e++) begin
            for (int k = 0; k < N; k++) begin
                push_prod(int'($urandom_range(0, 100)) - 50);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        wait_drain("random_drain");
        repeat (3) @(negedge clk);
        check("add_count", 32'(z_xfers), 32'(exp_adds));
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_prod_ack", 32'(prod_ack), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
